ltl_report_collector: RTL and testbench
=======================================

# ltl_report_collector

Downstream stage of each generated LTL automaton (`Automata_*`) in the runtime monitor. It samples the automaton's report outputs and tags every reporting cycle with the index of the symbol that caused it. Tagged events are buffered in a small FIFO and drained over a valid/ready port. The block also keeps a sticky first-violation record and drop statistics for the monitor CSR layer.

## Interface
Parameters:
- `NUM_REPORTS`, 4: width of the report vector (one bit per report STE).
- `FIFO_DEPTH`, 8: event FIFO entries; must be a power of 2 and ≥ 2.
- `IDX_W`, 32: symbol-index width.
- `DROP_W`, 16: drop-counter width.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `run`, in, 1: same strobe as the automaton's `run`; a symbol is consumed this cycle.
- `clear`, in, 1: synchronous flush of all state.
- `report_vec`, in, NUM_REPORTS: automaton `active_state` outputs of the report STEs.
- `evt_valid`, out, 1: head event is available.
- `evt_ready`, in, 1: consumer accepts the head event.
- `evt_mask`, out, NUM_REPORTS: report bits of the head event.
- `evt_index`, out, IDX_W: symbol index of the head event.
- `violation`, out, 1: sticky; at least one report has been seen.
- `first_mask`, out, NUM_REPORTS: mask of the first report since reset/clear.
- `first_index`, out, IDX_W: index of the first report.
- `overflow`, out, 1: sticky; at least one event has been dropped.
- `drop_cnt`, out, DROP_W: number of dropped events, saturating.
- `sym_cnt`, out, IDX_W: symbols consumed since reset/clear.

## Operation
- **Sampling.** Report STEs are registered, so `report_vec` for the symbol consumed at cycle t is valid at cycle t+1.
  - The block registers `run_q <= run` and `idx_q <= sym_cnt`.
  - The sample cycle is `run_q == 1`. A sample is reportable when `|report_vec`.
  - The event index equals the `sym_cnt` value at the cycle `run` was high: 0-based, the index of the offending symbol.
- **`sym_cnt`.** Increments by 1 on every `run`. Wraps modulo 2^IDX_W; there is no flag on wrap.
- **Push.** Every reportable sample pushes `{report_vec, idx_q}` into the FIFO.
- **Pop.** Occurs when `evt_valid && evt_ready`.
- **Full FIFO.**
  - A push in the same cycle as a pop is accepted; the occupancy is unchanged.
  - A push without a pop is dropped. `drop_cnt` increments (saturating at all-ones) and `overflow` is set.
- **Empty FIFO.** Push and pop cannot coincide because there is no bypass.
- **First-violation record.** On the first reportable sample with `violation == 0`, the block sets `violation` and captures `first_mask`/`first_index`. This happens even if that event is dropped. Later reports never modify the record.
- **`clear`.** Empties the FIFO and zeroes all counters, flags, the first record and `run_q`.
  - `clear` takes priority over a push or pop in the same cycle.
  - A `run` coincident with `clear` is not counted.
- **`reset`.** Asynchronous; same effect as `clear`, applied immediately regardless of `clk`.
  - Reset mid-stream discards all pending events.
  - A sample whose `run` preceded reset is never pushed.

## Timing
- Reset value of every output is 0: `evt_valid`, `evt_mask`, `evt_index`, `violation`, `first_mask`, `first_index`, `overflow`, `drop_cnt`, `sym_cnt`.
- `run` at cycle t, then report visible at t+1, then FIFO write at the t+1 edge, then `evt_valid` high at t+2. The same latency applies to `violation`.
- `evt_mask`/`evt_index` are registered FIFO head outputs. They are stable while `evt_valid && !evt_ready`.
- `evt_valid` never depends combinationally on `evt_ready`.
- Sustained throughput is one event per cycle.
- `sym_cnt` updates on the edge after `run`.

## Structure
- Shared package `ltl_monitor_pkg` holds:
  - `report_evt_t` packed struct `{mask, index}`, parameterised through package localparams `LTL_NUM_REPORTS` and `LTL_IDX_W`;
  - a default `LTL_FIFO_DEPTH`.
- One sub-module, `ltl_report_fifo`: a synchronous FIFO of `report_evt_t` with registered head, full/empty, and simultaneous push/pop.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide; full/empty are determined by MSB compare.
  - It has its own async reset and `flush` input.
- The top level holds `run_q`/`idx_q`, the counters, the sticky flags and the first-record registers.

## Test plan
- **Single report.** Reset, then `run` for symbols 0..4 with `report_vec = 4'b0100` only in the cycle after symbol 3. Expect: one event `mask=4'b0100`, `index=3`; `violation=1`; `first_index=3`; `evt_valid` rises 2 cycles after symbol 3's `run`.
- **Back-pressure/overflow.** `evt_ready=0`, 10 consecutive reportable samples, indices 0..9, `FIFO_DEPTH=8`. Expect: FIFO holds indices 0..7; `drop_cnt=2`; `overflow=1`. Drain returns 0..7 in order.
- **Full with simultaneous pop.** Fill to 8, then hold `evt_ready=1` while reporting each cycle. Expect: no drops; occupancy stays 8; indices stay contiguous.
- **Sticky first record.** Report `4'b0001` at index 5, then `4'b1000` at index 9. Expect: `first_mask=4'b0001` and `first_index=5` persist; both events are queued.
- **Clear/reset mid-stream.** Queue 3 events and assert `clear` in the same cycle as a push. Expect: the next cycle `evt_valid=0` and `sym_cnt=0`, with all flags 0. Repeat with asynchronous `reset` pulsed between clock edges; outputs drop to 0 before the next edge.
- **Index wrap.** `IDX_W=4`, 18 `run`s with a report on the last. Expect: `sym_cnt` wraps to 2; event `index=1`.

Source files
------------

// File: rtl/ltl_monitor_pkg.sv
// Shared types and defaults for the LTL runtime monitor report path.
package ltl_monitor_pkg;

    localparam int LTL_NUM_REPORTS = 4;
    localparam int LTL_IDX_W       = 32;
    localparam int LTL_FIFO_DEPTH  = 8;

    typedef struct packed {
        logic [LTL_NUM_REPORTS-1:0] mask;
        logic [LTL_IDX_W-1:0]       index;
    } report_evt_t;

endpackage

// File: rtl/ltl_report_fifo.sv
// Synchronous event FIFO with a registered head entry, flush, and
// simultaneous push/pop (a push into a full FIFO is taken only if a pop
// happens in the same cycle). There is no empty-FIFO bypass.
module ltl_report_fifo
    import ltl_monitor_pkg::*;
#(
    parameter type T     = report_evt_t,
    parameter int  DEPTH = LTL_FIFO_DEPTH
) (
    input  logic clk,
    input  logic reset,
    input  logic i_flush,
    input  logic i_push,
    input  T     i_din,
    input  logic i_pop,
    output T     o_head,
    output logic o_full,
    output logic o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    T           r_mem [DEPTH];
    T           r_head;
    logic [AW:0] r_wrPtr;
    logic [AW:0] r_rdPtr;

    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic        w_occOne;
    logic [AW:0] w_rdNext;

    assign w_empty  = (r_wrPtr == r_rdPtr);
    assign w_full   = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                      (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_pop    = i_pop && !w_empty;
    assign w_push   = i_push && (!w_full || w_pop);
    assign w_occOne = ((r_wrPtr - r_rdPtr) == PTR_ONE);
    assign w_rdNext = r_rdPtr + PTR_ONE;

    // Storage array; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr[AW-1:0]] <= i_din;
        end
    end

    // Read/write pointers; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else if (i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + PTR_ONE;
            if (w_pop)  r_rdPtr <= w_rdNext;
        end
    end

    // Head register: reloads from the next slot on pop, or takes the incoming
    // entry when it becomes the oldest one (empty, or last entry popped).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head <= '0;
        end else if (i_flush) begin
            r_head <= '0;
        end else if (w_pop) begin
            if (w_occOne) begin
                if (w_push) r_head <= i_din;
            end else begin
                r_head <= r_mem[w_rdNext[AW-1:0]];
            end
        end else if (w_push && w_empty) begin
            r_head <= i_din;
        end
    end

    assign o_head  = r_head;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/ltl_report_collector.sv
// Tags automaton report cycles with the index of the offending symbol,
// queues them for a valid/ready consumer and keeps first-violation and
// drop statistics for the CSR layer.
module ltl_report_collector
    import ltl_monitor_pkg::*;
#(
    parameter int NUM_REPORTS = LTL_NUM_REPORTS,
    parameter int FIFO_DEPTH  = LTL_FIFO_DEPTH,
    parameter int IDX_W       = LTL_IDX_W,
    parameter int DROP_W      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   clear,
    input  logic [NUM_REPORTS-1:0] report_vec,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [NUM_REPORTS-1:0] evt_mask,
    output logic [IDX_W-1:0]       evt_index,
    output logic                   violation,
    output logic [NUM_REPORTS-1:0] first_mask,
    output logic [IDX_W-1:0]       first_index,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_cnt,
    output logic [IDX_W-1:0]       sym_cnt
);

    // Same layout as report_evt_t, but sized by this instance's parameters.
    typedef struct packed {
        logic [NUM_REPORTS-1:0] mask;
        logic [IDX_W-1:0]       index;
    } evt_t;

    logic                   r_runQ;
    logic [IDX_W-1:0]       r_idxQ;
    logic [IDX_W-1:0]       r_symCnt;
    logic                   r_violation;
    logic [NUM_REPORTS-1:0] r_firstMask;
    logic [IDX_W-1:0]       r_firstIndex;
    logic                   r_overflow;
    logic [DROP_W-1:0]      r_dropCnt;

    logic w_sample;
    logic w_pop;
    logic w_drop;
    logic w_full;
    logic w_empty;
    evt_t w_pushEvt;
    evt_t w_head;

    assign w_sample        = r_runQ && (|report_vec);
    assign w_pop           = !w_empty && evt_ready;
    assign w_drop          = w_sample && w_full && !w_pop;
    assign w_pushEvt.mask  = report_vec;
    assign w_pushEvt.index = r_idxQ;

    ltl_report_fifo #(
        .T     (evt_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_flush (clear),
        .i_push  (w_sample),
        .i_din   (w_pushEvt),
        .i_pop   (evt_ready),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Symbol bookkeeping: delay run/index by one cycle to line up with the
    // registered report STEs, and count consumed symbols.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_runQ   <= 1'b0;
            r_idxQ   <= '0;
            r_symCnt <= '0;
        end else if (clear) begin
            r_runQ   <= 1'b0;
            r_idxQ   <= '0;
            r_symCnt <= '0;
        end else begin
            r_runQ <= run;
            r_idxQ <= r_symCnt;
            if (run) r_symCnt <= r_symCnt + IDX_W'(1);
        end
    end

    // Sticky first-violation record, captured even if the event is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_violation  <= 1'b0;
            r_firstMask  <= '0;
            r_firstIndex <= '0;
        end else if (clear) begin
            r_violation  <= 1'b0;
            r_firstMask  <= '0;
            r_firstIndex <= '0;
        end else if (w_sample && !r_violation) begin
            r_violation  <= 1'b1;
            r_firstMask  <= report_vec;
            r_firstIndex <= r_idxQ;
        end
    end

    // Drop statistics: sticky overflow flag and a saturating drop counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_dropCnt  <= '0;
        end else if (clear) begin
            r_overflow <= 1'b0;
            r_dropCnt  <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_dropCnt != {DROP_W{1'b1}}) r_dropCnt <= r_dropCnt + DROP_W'(1);
        end
    end

    assign evt_valid   = !w_empty;
    assign evt_mask    = w_head.mask;
    assign evt_index   = w_head.index;
    assign violation   = r_violation;
    assign first_mask  = r_firstMask;
    assign first_index = r_firstIndex;
    assign overflow    = r_overflow;
    assign drop_cnt    = r_dropCnt;
    assign sym_cnt     = r_symCnt;

endmodule

// File: tb/tb_ltl_report_collector.sv
// Scoreboard bench for ltl_report_collector: a behavioural model predicts
// queued events and status, a negedge monitor compares against the DUT.
module tb_ltl_report_collector;

    localparam int NR    = 4;
    localparam int DEPTH = 8;
    localparam int IW    = 32;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          run = 1'b0;
    logic          clear = 1'b0;
    logic          evt_ready = 1'b0;
    logic [NR-1:0] report_vec = '0;
    logic          evt_valid;
    logic [NR-1:0] evt_mask;
    logic [IW-1:0] evt_index;
    logic          violation;
    logic [NR-1:0] first_mask;
    logic [IW-1:0] first_index;
    logic          overflow;
    logic [DW-1:0] drop_cnt;
    logic [IW-1:0] sym_cnt;

    logic          run4 = 1'b0;
    logic [NR-1:0] rep4 = '0;
    logic          v4;
    logic [NR-1:0] mask4;
    logic [3:0]    idx4;
    logic          viol4;
    logic [NR-1:0] fmask4;
    logic [3:0]    fidx4;
    logic          ovf4;
    logic [DW-1:0] drop4;
    logic [3:0]    sym4;

    always #5 clk = ~clk;

    ltl_report_collector #(.NUM_REPORTS(NR), .FIFO_DEPTH(DEPTH), .IDX_W(IW), .DROP_W(DW)) dut (
        .clk(clk), .reset(reset), .run(run), .clear(clear), .report_vec(report_vec),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_mask(evt_mask), .evt_index(evt_index),
        .violation(violation), .first_mask(first_mask), .first_index(first_index),
        .overflow(overflow), .drop_cnt(drop_cnt), .sym_cnt(sym_cnt)
    );

    ltl_report_collector #(.NUM_REPORTS(NR), .FIFO_DEPTH(DEPTH), .IDX_W(4), .DROP_W(DW)) dutWrap (
        .clk(clk), .reset(reset), .run(run4), .clear(1'b0), .report_vec(rep4),
        .evt_valid(v4), .evt_ready(1'b1), .evt_mask(mask4), .evt_index(idx4),
        .violation(viol4), .first_mask(fmask4), .first_index(fidx4),
        .overflow(ovf4), .drop_cnt(drop4), .sym_cnt(sym4)
    );

    typedef struct {
        logic [NR-1:0] mask;
        logic [IW-1:0] index;
    } ev_t;

    ev_t           expQ[$];
    int            vectors = 0;
    int            miscompares = 0;
    bit            monEn = 1'b0;

    int            occ;
    bit            mRunQ;
    logic [IW-1:0] mIdxQ;
    logic [IW-1:0] mSym;
    bit            mViol;
    logic [NR-1:0] mFMask;
    logic [IW-1:0] mFIdx;
    bit            mOvf;
    int            mDrop;

    function automatic void checkOutput(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void modelReset();
        occ    = 0;
        mRunQ  = 1'b0;
        mIdxQ  = '0;
        mSym   = '0;
        mViol  = 1'b0;
        mFMask = '0;
        mFIdx  = '0;
        mOvf   = 1'b0;
        mDrop  = 0;
        expQ.delete();
    endfunction

    // Effect of one clock edge, given the inputs held during the cycle before it.
    function automatic void modelEdge();
        bit  pop;
        bit  sample;
        ev_t e;
        if (clear) begin
            modelReset();
            return;
        end
        pop    = (occ > 0) && evt_ready;
        sample = mRunQ && (report_vec != 0);
        if (sample) begin
            if (!mViol) begin
                mViol  = 1'b1;
                mFMask = report_vec;
                mFIdx  = mIdxQ;
            end
            if (occ < DEPTH || pop) begin
                e.mask  = report_vec;
                e.index = mIdxQ;
                expQ.push_back(e);
                occ++;
            end else begin
                mOvf = 1'b1;
                if (mDrop < (1 << DW) - 1) mDrop++;
            end
        end
        if (pop) occ--;
        mIdxQ = mSym;
        mRunQ = run;
        if (run) mSym = mSym + 1;
    endfunction

    task automatic applyStimulus(input logic r, input logic [NR-1:0] rep, input logic rdy, input logic clr);
        @(posedge clk);
        modelEdge();
        #1;
        run        = r;
        report_vec = rep;
        evt_ready  = rdy;
        clear      = clr;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, rdy, 1'b0);
    endtask

    function automatic logic [NR-1:0] rndMask();
        return NR'($urandom_range(1, 15));
    endfunction

    // Monitor: compares the FIFO head against the scoreboard and pops on handshake.
    always @(negedge clk) begin
        if (monEn) begin
            ev_t h;
            checkOutput("evt_valid", evt_valid, occ > 0);
            if (occ > 0) begin
                if (expQ.size() == 0) begin
                    checkOutput("scoreboard_nonempty", 0, 1);
                end else begin
                    h = expQ[0];
                    checkOutput("evt_mask", evt_mask, h.mask);
                    checkOutput("evt_index", evt_index, h.index);
                    if (evt_ready) void'(expQ.pop_front());
                end
            end
            checkOutput("violation", violation, mViol);
            checkOutput("first_mask", first_mask, mFMask);
            checkOutput("first_index", first_index, mFIdx);
            checkOutput("overflow", overflow, mOvf);
            checkOutput("drop_cnt", drop_cnt, mDrop);
            checkOutput("sym_cnt", sym_cnt, mSym);
        end
    end

    initial begin
        int  wrapRuns;
        bit  found;
        modelReset();
        #2;
        checkOutput("reset_evt_valid", evt_valid, 0);
        checkOutput("reset_violation", violation, 0);
        checkOutput("reset_sym_cnt", sym_cnt, 0);
        checkOutput("reset_drop_cnt", drop_cnt, 0);
        checkOutput("reset_evt_index", evt_index, 0);
        #10;
        reset = 1'b0;
        monEn = 1'b1;

        // Single report on symbol 3
        for (int k = 0; k < 8; k++)
            applyStimulus(k < 5, (k == 4) ? 4'b0100 : 4'b0000, 1'b0, 1'b0);
        checkOutput("single_first_index", first_index, 3);
        idle(3, 1'b1);

        // Back-pressure with overflow: samples for indices 0..9
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 11; k++)
            applyStimulus(k < 10, (k >= 1) ? rndMask() : 4'b0000, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("overflow_drop_cnt", drop_cnt, 2);
        checkOutput("overflow_flag", overflow, 1);
        idle(10, 1'b1);

        // Full FIFO with simultaneous pop
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 20; k++)
            applyStimulus(1'b1, (k >= 1) ? rndMask() : 4'b0000, k >= 9, 1'b0);
        applyStimulus(1'b0, rndMask(), 1'b1, 1'b0);
        checkOutput("fullpop_drop_cnt", drop_cnt, 0);
        idle(10, 1'b1);

        // Sticky first record
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 12; k++)
            applyStimulus(k < 10, (k == 6) ? 4'b0001 : ((k == 10) ? 4'b1000 : 4'b0000), 1'b0, 1'b0);
        checkOutput("sticky_first_mask", first_mask, 4'b0001);
        checkOutput("sticky_first_index", first_index, 5);
        idle(4, 1'b1);

        // Clear coincident with a push
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b1, (k >= 1) ? rndMask() : 4'b0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0010, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("clear_evt_valid", evt_valid, 0);
        checkOutput("clear_sym_cnt", sym_cnt, 0);
        checkOutput("clear_violation", violation, 0);

        // Asynchronous reset between edges, with a pending sample
        for (int k = 0; k < 4; k++)
            applyStimulus(1'b1, (k >= 1) ? rndMask() : 4'b0000, 1'b0, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("areset_evt_valid", evt_valid, 0);
        checkOutput("areset_violation", violation, 0);
        checkOutput("areset_sym_cnt", sym_cnt, 0);
        checkOutput("areset_first_index", first_index, 0);
        modelReset();
        run = 1'b0;
        #1;
        reset = 1'b0;
        idle(3, 1'b1);

        // Randomised traffic
        for (int k = 0; k < 400; k++)
            applyStimulus($urandom_range(0, 9) < 6,
                          ($urandom_range(0, 9) < 5) ? rndMask() : 4'b0000,
                          $urandom_range(0, 9) < 6,
                          $urandom_range(0, 79) == 0);
        idle(12, 1'b1);
        checkOutput("final_scoreboard_empty", expQ.size(), 0);

        // Index wrap on a 4-bit index instance
        wrapRuns = 18;
        for (int k = 0; k <= wrapRuns; k++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            run4 = (k < wrapRuns);
            rep4 = (k == wrapRuns) ? 4'b0010 : 4'b0000;
        end
        checkOutput("wrap_sym_cnt", sym4, wrapRuns % 16);
        found = 1'b0;
        for (int k = 0; k < 6 && !found; k++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            run4 = 1'b0;
            rep4 = '0;
            if (v4) begin
                found = 1'b1;
                checkOutput("wrap_evt_index", idx4, (wrapRuns - 1) % 16);
                checkOutput("wrap_evt_mask", mask4, 4'b0010);
            end
        end
        if (!found) checkOutput("wrap_evt_timeout", 0, 1);

        monEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
